r2sdf_bf_stage32: RTL and testbench

- Radix-2 single-path delay-feedback (R2SDF) butterfly stage for the 128-point FFT pipeline, 32-deep delay line.
- Sits directly downstream of the stage's twiddle/phase generator. It consumes that generator's `state` and `w_r`/`w_i` in the same cycle as the matching input sample.
- Produces one serial complex sample per accepted input:
  - butterfly sums in phase BF;
  - twiddle-rotated differences in phase TW.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/r2sdf_bf_stage32_if.sv | 26 ++
 rtl/sdf_cmul.sv | 24 ++
 rtl/r2sdf_bf_stage32.sv | 93 +++++++++
 tb/tb_r2sdf_bf_stage32.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT pipeline types: data/twiddle widths, phase codes, complex sample.
// Imported by every butterfly stage and the complex multiplier.
package fft_pkg;

    localparam int DW      = 24;
    localparam int WW      = 24;
    localparam int TW_FRAC = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BF   = 2'd1,
        ST_TW   = 2'd2
    } phase_e;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [WW-1:0] re;
        logic signed [WW-1:0] im;
    } tw_t;

endpackage

// File: rtl/r2sdf_bf_stage32_if.sv
// Sample bus of an SDF stage: in_valid/din/state/w in, out_valid/dout out.
// master = upstream driver side, slave = the stage itself.
interface r2sdf_bf_stage32_if;
    import fft_pkg::*;

    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic [1:0]           state;
    logic signed [WW-1:0] w_r;
    logic signed [WW-1:0] w_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );

endinterface

// File: rtl/sdf_cmul.sv
// Combinational complex multiply p_o = (d_i * tw_i) >>> TW_FRAC, low DW bits.
// Ports: d_i sample, tw_i Q.TW_FRAC twiddle, p_o rotated sample.
module sdf_cmul
    import fft_pkg::*;
(
    input  cplx_t d_i,
    input  tw_t   tw_i,
    output cplx_t p_o
);
    // One guard bit so the sum of two full products never overflows.
    localparam int PW = DW + WW + 1;

    logic signed [PW-1:0] dr, di, wr, wi;

    assign dr = {{(PW-DW){d_i.re[DW-1]}}, d_i.re};
    assign di = {{(PW-DW){d_i.im[DW-1]}}, d_i.im};
    assign wr = {{(PW-WW){tw_i.re[WW-1]}}, tw_i.re};
    assign wi = {{(PW-WW){tw_i.im[WW-1]}}, tw_i.im};

    // Arithmetic shift floors; the cast keeps the low DW bits.
    assign p_o.re = DW'((dr * wr - di * wi) >>> TW_FRAC);
    assign p_o.im = DW'((dr * wi + di * wr) >>> TW_FRAC);

endmodule

// File: rtl/r2sdf_bf_stage32.sv
// R2SDF butterfly stage with a DEPTH-deep feedback delay line, 1-cycle latency.
// Ports: clk, rst_n (async low), bus (slave: din/state/w in, dout/out_valid out).
module r2sdf_bf_stage32
    import fft_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    r2sdf_bf_stage32_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] ptr_q, ptr_d;
    logic          ov_q, ov_d;
    cplx_t         dout_q, dout_d;
    cplx_t         mem_q [DEPTH];

    cplx_t x, d, sum, diff, rot, mem_wd;
    tw_t   w;
    logic  mem_we, is_bf, is_tw;

    assign x.re = bus.din_r;
    assign x.im = bus.din_i;
    assign w.re = bus.w_r;
    assign w.im = bus.w_i;

    // Read-before-write: d is the value stored DEPTH samples ago.
    assign d = mem_q[ptr_q];

    assign sum.re  = d.re + x.re;
    assign sum.im  = d.im + x.im;
    assign diff.re = d.re - x.re;
    assign diff.im = d.im - x.im;

    sdf_cmul u_cmul (
        .d_i  (d),
        .tw_i (w),
        .p_o  (rot)
    );

    // Code 3 falls through to FILL.
    assign is_bf = (bus.state == ST_BF);
    assign is_tw = (bus.state == ST_TW);

    always_comb begin
        ptr_d  = ptr_q;
        ov_d   = 1'b0;
        dout_d = dout_q;
        mem_we = 1'b0;
        mem_wd = x;
        if (bus.in_valid) begin
            ptr_d  = ptr_q + 1'b1;
            mem_we = 1'b1;
            unique case (1'b1)
                is_bf: begin
                    dout_d = sum;
                    mem_wd = diff;
                    ov_d   = 1'b1;
                end
                is_tw: begin
                    dout_d = rot;
                    ov_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            ov_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            ov_q   <= ov_d;
            dout_q <= dout_d;
        end
    end

    // Contents are don't-care until written; out_valid gates them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wd;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.dout_r    = dout_q.re;
    assign bus.dout_i    = dout_q.im;

endmodule

// File: tb/tb_r2sdf_bf_stage32.sv
// Self-checking bench for r2sdf_bf_stage32 against a frame-level FFT model.
// Drives the generator sequence, stalls, resets and random data.
module tb_r2sdf_bf_stage32;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    r2sdf_bf_stage32_if bus ();

    r2sdf_bf_stage32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    int     n_acc  = 0;
    longint hr[$];
    longint hi[$];
    longint last_r = 0;
    longint last_i = 0;
    bit     w_force = 1'b0;
    longint wf_r = 0;
    longint wf_i = 0;

    task automatic check_eq(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint sx24(longint v);
        logic [23:0] t;
        t = v[23:0];
        return longint'($signed(t));
    endfunction

    // Generator: 32 FILL, then BF x32 / TW x32 alternating.
    function automatic int gen_state(int n);
        if (n < 32) return 0;
        return ((((n - 32) / 32) % 2) == 0) ? 1 : 2;
    endfunction

    // W64^k = exp(-j*2*pi*k/64) in Q8, rounded to nearest.
    function automatic void twid(int k, output longint r, output longint i);
        real a;
        a = 2.0 * 3.141592653589793 * real'(k) / 64.0;
        r = longint'($rtoi($floor(256.0 * $cos(a) + 0.5)));
        i = longint'($rtoi($floor(-256.0 * $sin(a) + 0.5)));
    endfunction

    function automatic void cmul_ref(longint ar, longint ai,
                                     longint br, longint bi,
                                     output longint r, output longint i);
        r = sx24((ar * br - ai * bi) >>> 8);
        i = sx24((ar * bi + ai * br) >>> 8);
    endfunction

    task automatic model_clear();
        n_acc = 0;
        hr.delete();
        hi.delete();
        last_r = 0;
        last_i = 0;
    endtask

    task automatic step(bit v, longint xr, longint xi);
        int     st;
        longint wr, wi, er, ei, dr, di;
        bit     eov;
        @(negedge clk);
        st = gen_state(n_acc);
        twid(n_acc % 32, wr, wi);
        if (w_force) begin
            wr = wf_r;
            wi = wf_i;
        end
        bus.in_valid = v;
        bus.din_r    = xr[23:0];
        bus.din_i    = xi[23:0];
        bus.state    = st[1:0];
        bus.w_r      = wr[23:0];
        bus.w_i      = wi[23:0];
        @(posedge clk);
        #1;
        eov = 1'b0;
        er  = last_r;
        ei  = last_i;
        if (v) begin
            hr.push_back(sx24(xr));
            hi.push_back(sx24(xi));
            if (st == 1) begin
                eov = 1'b1;
                er  = sx24(hr[n_acc-32] + hr[n_acc]);
                ei  = sx24(hi[n_acc-32] + hi[n_acc]);
            end else if (st == 2) begin
                eov = 1'b1;
                dr  = sx24(hr[n_acc-64] - hr[n_acc-32]);
                di  = sx24(hi[n_acc-64] - hi[n_acc-32]);
                cmul_ref(dr, di, wr, wi, er, ei);
            end
            n_acc++;
        end
        check_eq("out_valid", longint'(bus.out_valid), longint'(eov));
        check_eq("dout_r", longint'(bus.dout_r), er);
        check_eq("dout_i", longint'(bus.dout_i), ei);
        check_eq("ptr", longint'(dut.ptr_q), longint'(n_acc % 32));
        last_r = er;
        last_i = ei;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ov", longint'(bus.out_valid), 0);
        check_eq("rst_dr", longint'(bus.dout_r), 0);
        check_eq("rst_di", longint'(bus.dout_i), 0);
        check_eq("rst_ptr", longint'(dut.ptr_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ov", longint'(bus.out_valid), 0);
        check_eq("mid_rst_dr", longint'(bus.dout_r), 0);
        check_eq("mid_rst_di", longint'(bus.dout_i), 0);
        check_eq("mid_rst_ptr", longint'(dut.ptr_q), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic ramp(int stall_at, int stop_at);
        for (int k = 0; k < stop_at; k++) begin
            if (k == stall_at) repeat (5) step(1'b0, 0, 0);
            step(1'b1, longint'(k), 0);
            case (k)
                31: check_eq("ramp_fill_quiet", longint'(bus.out_valid), 0);
                32: check_eq("ramp_bf_first", longint'(bus.dout_r), 32);
                63: check_eq("ramp_bf_last", longint'(bus.dout_r), 94);
                64: begin
                    check_eq("ramp_tw0_r", longint'(bus.dout_r), -32);
                    check_eq("ramp_tw0_i", longint'(bus.dout_i), 0);
                end
                72: begin
                    check_eq("ramp_tw8_r", longint'(bus.dout_r), -23);
                    check_eq("ramp_tw8_i", longint'(bus.dout_i), 22);
                end
                80: begin
                    check_eq("ramp_tw16_r", longint'(bus.dout_r), 0);
                    check_eq("ramp_tw16_i", longint'(bus.dout_i), 32);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        bus.state    = '0;
        bus.w_r      = '0;
        bus.w_i      = '0;
        rst_n        = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("init_ov", longint'(bus.out_valid), 0);
        check_eq("init_dr", longint'(bus.dout_r), 0);
        check_eq("init_di", longint'(bus.dout_i), 0);
        check_eq("init_ptr", longint'(dut.ptr_q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        ramp(-1, 96);

        do_reset();
        ramp(40, 96);

        do_reset();
        ramp(-1, 50);
        mid_reset();
        ramp(-1, 96);

        do_reset();
        for (int k = 0; k < 96; k++) begin
            step(1'b1, 64'sd8388607, 0);
            if (k == 32) check_eq("wrap_bf", longint'(bus.dout_r), -2);
            if (k == 64) begin
                check_eq("wrap_tw_r", longint'(bus.dout_r), 0);
                check_eq("wrap_tw_i", longint'(bus.dout_i), 0);
            end
        end

        do_reset();
        w_force = 1'b1;
        wf_r = 255;
        wf_i = 0;
        for (int k = 0; k < 96; k++) begin
            step(1'b1, (k >= 32 && k < 64) ? 1 : 0, 0);
            if (k == 64) begin
                check_eq("floor_neg_r", longint'(bus.dout_r), -1);
                check_eq("floor_neg_i", longint'(bus.dout_i), 0);
            end
        end
        w_force = 1'b0;

        do_reset();
        while (n_acc < 32 + 64 * 4) begin
            if ($urandom_range(4) == 0) step(1'b0, 0, 0);
            else step(1'b1, sx24(longint'($urandom)), sx24(longint'($urandom)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
